hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard and sequencing controller for the RV32I 5-stage core. Drives PC/IF_ID/ID_EX/EX_MEM write-enables and flushes.
//  Handles load-use stalls, taken-branch/jump redirects resolved in EX, and multi-cycle data-memory waits.
//  Keeps saturating stall/flush performance counters. Sits beside the ID/EX pipeline register; its ID_EXFlush feeds that register.
// PARAMETERS
//  CNT_W      32  width of perf counters stall_cnt / flush_cnt
//  LU_CYCLES  1   bubbles inserted per load-use hazard (1..3)
// PORTS
//  clk             in   1   system clock; all state updates on rising edge
//  reset           in   1   synchronous, active-high reset
//  ID_ReadRegNum1  in   5   rs1 of instruction in ID
//  ID_ReadRegNum2  in   5   rs2 of instruction in ID
//  ID_uses_rs1     in   1   ID instruction reads rs1
//  ID_uses_rs2     in   1   ID instruction reads rs2
//  EX_cntl_MemRead in   1   instruction in EX is a load
//  EX_WriteRegNum  in   5   rd of instruction in EX
//  EX_redirect     in   1   taken branch or jump resolved in EX this cycle
//  MEM_busy        in   1   data memory not ready; MEM stage must hold
//  PCWrite         out  1   PC update enable
//  IF_IDWrite      out  1   IF/ID register load enable
//  IF_IDFlush      out  1   IF/ID register clears to bubble
//  ID_EXWrite      out  1   ID/EX register load enable
//  ID_EXFlush      out  1   ID/EX register clears to bubble
//  EX_MEMWrite     out  1   EX/MEM register load enable
//  stall_cnt       out  CNT_W  cycles with PCWrite=0 (saturating)
//  flush_cnt       out  CNT_W  redirects applied (saturating)
// BEHAVIOUR
//  States: RUN, LU_STALL, MEM_WAIT. Enables/flushes combinational from state+inputs; state/counters registered.
//  reset: state=RUN, lu_left=0, redir_pend=0, counters=0. Outputs then follow RUN defaults.
//  RUN defaults: all *Write=1, all *Flush=0.
//  Load-use hit = EX_cntl_MemRead & EX_WriteRegNum!=0 & ((ID_uses_rs1 & rs1==rd)|(ID_uses_rs2 & rs2==rd)).
//  Priority per cycle: MEM_busy > redirect (EX_redirect or redir_pend) > load-use > none.
//  MEM_busy=1 (any state): PCWrite=IF_IDWrite=ID_EXWrite=EX_MEMWrite=0, no flush; next=MEM_WAIT.
//    If EX_redirect=1 while busy: set redir_pend=1 (EX holds, so redirect applied on exit).
//  MEM_WAIT & !MEM_busy: all writes=1; if redir_pend apply redirect this cycle, clear redir_pend; next=RUN.
//  Redirect: PCWrite=1, IF_IDFlush=1, ID_EXFlush=1, EX_MEMWrite=1; flush_cnt+=1; cancels any load-use stall (lu_left=0); next=RUN.
//  Load-use hit in RUN: PCWrite=0, IF_IDWrite=0, ID_EXFlush=1; lu_left=LU_CYCLES-1; next=LU_STALL if lu_left>0 else RUN.
//  LU_STALL: same outputs as load-use stall; lu_left-=1; exit to RUN when lu_left reaches 0.
//  Reset mid-stall/mid-wait: next cycle RUN defaults, redir_pend lost.
//  stall_cnt increments every cycle PCWrite=0; counters saturate at all-ones, never wrap.
//  Flush and Write both 1 on a register means load bubble (flush wins inside the register).
// TESTING
//  1 reset=1 two cycles -> PCWrite=1, all flushes 0, stall_cnt=flush_cnt=0.
//  2 EX load rd=5, ID rs1=5 uses_rs1=1 -> one cycle PCWrite=0,IF_IDWrite=0,ID_EXFlush=1; stall_cnt=1.
//  3 EX load rd=0, ID rs1=0 -> no stall; ID rs2=5 with uses_rs2=0 vs rd=5 -> no stall.
//  4 EX_redirect=1 same cycle as load-use hit -> IF_IDFlush=ID_EXFlush=1, PCWrite=1; flush_cnt=1, stall_cnt unchanged.
//  5 MEM_busy 3 cycles with EX_redirect=1 in cycle 2 -> all writes 0 for 3 cycles; cycle 4 redirect flushes, flush_cnt=1, stall_cnt=3.
//  6 CNT_W=4, 20 load-use stalls -> stall_cnt holds 4'hF; reset during MEM_WAIT -> RUN defaults next cycle.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl - hazard and sequencing controller for the RV32I 5-stage core.
//   Generates the PC, IF/ID, ID/EX and EX/MEM write-enables and flushes.
//   It covers three cases:
//     - load-use stalls, with LU_CYCLES bubbles per hazard;
//     - taken-branch/jump redirects resolved in EX;
//     - data-memory wait states.
//   It also keeps saturating stall and flush performance counters.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   ID_ReadRegNum1/2         rs1/rs2 of the ID instruction
//   ID_uses_rs1/2            ID instruction actually reads rs1/rs2
//   EX_cntl_MemRead          EX instruction is a load
//   EX_WriteRegNum           rd of the EX instruction
//   EX_redirect              taken branch/jump resolved in EX
//   MEM_busy                 data memory not ready, MEM holds
//   PCWrite .. EX_MEMWrite   pipeline register enables/flushes (combinational)
//   stall_cnt                cycles with PCWrite=0 (saturating)
//   flush_cnt                redirects applied (saturating)
module hazard_ctrl #(
  parameter int CNT_W     = 32,
  parameter int LU_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_ReadRegNum1,
  input  logic [4:0]       ID_ReadRegNum2,
  input  logic             ID_uses_rs1,
  input  logic             ID_uses_rs2,
  input  logic             EX_cntl_MemRead,
  input  logic [4:0]       EX_WriteRegNum,
  input  logic             EX_redirect,
  input  logic             MEM_busy,
  output logic             PCWrite,
  output logic             IF_IDWrite,
  output logic             IF_IDFlush,
  output logic             ID_EXWrite,
  output logic             ID_EXFlush,
  output logic             EX_MEMWrite,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_e;

  // Extra bubbles still owed after the first one of a load-use stall.
  localparam logic [1:0] LU_INIT = 2'(LU_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       lu_left_q, lu_left_d;
  logic             redir_pend_q, redir_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             lu_hit, redir_apply;

  assign lu_hit = EX_cntl_MemRead && (EX_WriteRegNum != 5'd0) &&
                  ((ID_uses_rs1 && (ID_ReadRegNum1 == EX_WriteRegNum)) ||
                   (ID_uses_rs2 && (ID_ReadRegNum2 == EX_WriteRegNum)));

  always_comb begin
    PCWrite      = 1'b1;
    IF_IDWrite   = 1'b1;
    IF_IDFlush   = 1'b0;
    ID_EXWrite   = 1'b1;
    ID_EXFlush   = 1'b0;
    EX_MEMWrite  = 1'b1;
    state_d      = state_q;
    lu_left_d    = lu_left_q;
    redir_pend_d = redir_pend_q;
    redir_apply  = 1'b0;

    if (MEM_busy) begin
      // Whole front of the pipe freezes. A redirect seen now is remembered
      // because EX holds and would otherwise be lost.
      PCWrite     = 1'b0;
      IF_IDWrite  = 1'b0;
      ID_EXWrite  = 1'b0;
      EX_MEMWrite = 1'b0;
      state_d     = MEM_WAIT;
      if (EX_redirect) redir_pend_d = 1'b1;
    end else if (EX_redirect || redir_pend_q) begin
      IF_IDFlush   = 1'b1;
      ID_EXFlush   = 1'b1;
      redir_apply  = 1'b1;
      lu_left_d    = 2'd0;
      redir_pend_d = 1'b0;
      state_d      = RUN;
    end else if (state_q == MEM_WAIT) begin
      // Exit cycle of a memory wait: everything advances.
      state_d = RUN;
    end else if (state_q == LU_STALL) begin
      PCWrite    = 1'b0;
      IF_IDWrite = 1'b0;
      ID_EXFlush = 1'b1;
      lu_left_d  = 2'(lu_left_q - 2'd1);
      state_d    = (lu_left_q == 2'd1) ? RUN : LU_STALL;
    end else if (lu_hit) begin
      PCWrite    = 1'b0;
      IF_IDWrite = 1'b0;
      ID_EXFlush = 1'b1;
      lu_left_d  = LU_INIT;
      state_d    = (LU_INIT != 2'd0) ? LU_STALL : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      lu_left_q    <= 2'd0;
      redir_pend_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      lu_left_q    <= lu_left_d;
      redir_pend_q <= redir_pend_d;
      if (!PCWrite && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (redir_apply && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
